// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default ack watchdog depth and the watchdog counter sizing helper.
package ifetch_pkg;

    localparam int STATE_W         = 3;
    localparam int ACK_TIMEOUT_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    // Counter width able to hold 0..timeout; never narrower than one bit so
    // a disabled watchdog (timeout 0) still yields a legal vector.
    function automatic int wdog_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive cycles a memory request waits without an ack and
// flags expiry once the configured limit has been reached with no ack.
module ack_watchdog
    import ifetch_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    localparam int              CNT_W   = wdog_cnt_w(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(ACK_TIMEOUT);
    localparam logic            WDOG_ON = (ACK_TIMEOUT > 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] count;

    // Waiting-cycle counter: restarts on ack or when not waiting, saturates at the limit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !enable || ack) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

    // An ack arriving on the expiry cycle is a normal completion, not an error.
    assign expired = WDOG_ON & enable & ~ack & (count == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: samples the PC, issues a word-aligned read over a req/ack
// handshake, holds the returned word in IR until decode accepts it, pulses
// pc_inc once per delivered instruction, and supports branch flush plus an
// ack watchdog that parks the stage in an error state until reset.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              pc_inc,
    output logic              fetch_err
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_t      state;
    logic [ADDR_W-1:0] aligned_pc;
    logic              waiting;
    logic              wdog_expired;

    // Word alignment is a pure mask; the low PC bits never reach the bus.
    assign aligned_pc = pc & ALIGN_MASK;
    assign waiting    = (state == ST_REQ) || (state == ST_DRAIN);

    ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .ack     (mem_ack),
        .expired (wdog_expired)
    );

    // Fetch FSM with all outputs registered; reset overrides every state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ir_valid  <= 1'b0;
            ir        <= '0;
            ir_pc     <= '0;
            pc_inc    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            pc_inc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_en && !flush) begin
                        mem_req  <= 1'b1;
                        mem_addr <= aligned_pc;
                        state    <= ST_REQ;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // The bus request cannot be withdrawn; a flush only marks the data as unwanted.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!flush) begin
                            ir       <= mem_rdata;
                            ir_pc    <= mem_addr;
                            ir_valid <= 1'b1;
                            pc_inc   <= 1'b1;
                            state    <= ST_HOLD;
                        end else begin
                            state    <= ST_IDLE;
                        end
                    end else if (wdog_expired) begin
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_ERR;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (wdog_expired) begin
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_ERR;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (flush || ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        state    <= ST_HOLD;
                    end
                end
                ST_ERR: begin
                    mem_req  <= 1'b0;
                    ir_valid <= 1'b0;
                    state    <= ST_ERR;
                end
                default: begin
                    mem_req  <= 1'b0;
                    ir_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus pushes expected bus
// addresses and fetched instructions into queues; a negedge monitor pops and
// compares whenever the DUT raises mem_req or ir_valid.
module tb_instr_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic              flush;
    logic [ADDR_W-1:0] pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              pc_inc;
    logic              fetch_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int pc_inc_seen = 0;
    int n_exp_inc  = 0;

    logic [ADDR_W-1:0] exp_req[$];
    logic [ADDR_W-1:0] exp_ir_pc[$];
    logic [DATA_W-1:0] exp_ir[$];

    logic prev_req   = 1'b0;
    logic prev_valid = 1'b0;

    instr_fetch #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .pc_inc    (pc_inc),
        .fetch_err (fetch_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare bus requests and delivered instructions against the scoreboard.
    always @(negedge clock) begin
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] ep;
        logic [DATA_W-1:0] ed;
        if (mem_req === 1'b1 && prev_req === 1'b0) begin
            if (exp_req.size() == 0) begin
                chk("unexpected_mem_req", {63'd0, 1'b1}, 64'd0);
            end else begin
                ea = exp_req.pop_front();
                chk("mem_addr", {32'd0, mem_addr}, {32'd0, ea});
            end
        end
        if (ir_valid === 1'b1 && prev_valid === 1'b0) begin
            if (exp_ir.size() == 0) begin
                chk("unexpected_ir_valid", {63'd0, 1'b1}, 64'd0);
            end else begin
                ed = exp_ir.pop_front();
                ep = exp_ir_pc.pop_front();
                chk("ir", {32'd0, ir}, {32'd0, ed});
                chk("ir_pc", {32'd0, ir_pc}, {32'd0, ep});
            end
        end
        if (pc_inc === 1'b1 || (ir_valid === 1'b1 && prev_valid === 1'b0)) begin
            chk("pc_inc_with_new_ir", {63'd0, pc_inc}, {63'd0, (ir_valid && !prev_valid)});
        end
        if (pc_inc === 1'b1) begin
            pc_inc_seen++;
        end
        prev_req   = mem_req;
        prev_valid = ir_valid;
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic start_fetch(input logic [ADDR_W-1:0] p);
        pc       = p;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] data, input int delay);
        logic [ADDR_W-1:0] a;
        a = {p[ADDR_W-1:2], 2'b00};
        exp_req.push_back(a);
        exp_ir_pc.push_back(a);
        exp_ir.push_back(data);
        n_exp_inc++;
        start_fetch(p);
        repeat (delay) step();
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
    endtask

    task automatic release_ir();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("ir_valid_after_ready", {63'd0, ir_valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        fetch_en  = 1'b1;
        flush     = 1'b0;
        pc        = 32'h0000_0104;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        ir_ready  = 1'b0;

        // Reset held 3 cycles with fetch_en and ack active.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
            chk("rst_ir_valid", {63'd0, ir_valid}, 64'd0);
            chk("rst_pc_inc", {63'd0, pc_inc}, 64'd0);
        end
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_ir", {32'd0, ir}, 64'd0);
        chk("rst_ir_pc", {32'd0, ir_pc}, 64'd0);
        chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
        fetch_en  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        reset     = 1'b1;
        step();
        chk("idle_no_req", {63'd0, mem_req}, 64'd0);

        // Single fetch, ack two cycles after the request, then back-pressure.
        do_fetch(32'h0000_0104, 32'h8C22_0004, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ir_valid", {63'd0, ir_valid}, 64'd1);
            chk("bp_ir", {32'd0, ir}, {32'd0, 32'h8C22_0004});
            chk("bp_ir_pc", {32'd0, ir_pc}, {32'd0, 32'h0000_0104});
            chk("bp_no_req", {63'd0, mem_req}, 64'd0);
            chk("bp_no_pc_inc", {63'd0, pc_inc}, 64'd0);
        end
        release_ir();
        chk("pc_inc_count_single", pc_inc_seen, 64'd1);

        // Flush while waiting for ack: request held until ack, data dropped.
        exp_req.push_back(32'h0000_0300);
        start_fetch(32'h0000_0300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_req_1", {63'd0, mem_req}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_req_2", {63'd0, mem_req}, 64'd1);
        step();
        chk("drain_req_3", {63'd0, mem_req}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack   = 1'b0;
        chk("drain_done_req", {63'd0, mem_req}, 64'd0);
        chk("drain_no_ir", {63'd0, ir_valid}, 64'd0);
        chk("pc_inc_count_flush", pc_inc_seen, 64'd1);
        do_fetch(32'h0000_0200, 32'h2008_0001, 0);
        release_ir();

        // Flush and ack in the same cycle.
        exp_req.push_back(32'h0000_0400);
        start_fetch(32'h0000_0400);
        mem_ack   = 1'b1;
        flush     = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        flush   = 1'b0;
        chk("flush_ack_req", {63'd0, mem_req}, 64'd0);
        chk("flush_ack_ir_valid", {63'd0, ir_valid}, 64'd0);
        step();
        chk("flush_ack_idle", {63'd0, mem_req}, 64'd0);

        // Flush and ir_ready together in HOLD; unaligned pc is masked.
        do_fetch(32'h0000_0507, 32'hAAAA_5555, 1);
        flush    = 1'b1;
        ir_ready = 1'b1;
        step();
        flush    = 1'b0;
        ir_ready = 1'b0;
        chk("hold_flush_ir_valid", {63'd0, ir_valid}, 64'd0);
        step();
        chk("hold_flush_idle", {63'd0, mem_req}, 64'd0);

        // Watchdog expiry: no ack ever.
        exp_req.push_back(32'h0000_0600);
        start_fetch(32'h0000_0600);
        for (int i = 0; i < 16; i++) begin
            chk("wd_wait_req", {63'd0, mem_req}, 64'd1);
            chk("wd_wait_err", {63'd0, fetch_err}, 64'd0);
            step();
        end
        chk("wd_last_wait_req", {63'd0, mem_req}, 64'd1);
        chk("wd_last_wait_err", {63'd0, fetch_err}, 64'd0);
        step();
        chk("wd_err", {63'd0, fetch_err}, 64'd1);
        chk("wd_err_req", {63'd0, mem_req}, 64'd0);
        fetch_en = 1'b1;
        mem_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_sticky", {63'd0, fetch_err}, 64'd1);
            chk("err_no_req", {63'd0, mem_req}, 64'd0);
            chk("err_no_ir", {63'd0, ir_valid}, 64'd0);
        end
        fetch_en = 1'b0;
        mem_ack  = 1'b0;
        reset    = 1'b0;
        step();
        reset    = 1'b1;
        chk("err_cleared_by_reset", {63'd0, fetch_err}, 64'd0);

        // Ack on the expiry cycle completes normally.
        exp_req.push_back(32'h0000_0700);
        exp_ir_pc.push_back(32'h0000_0700);
        exp_ir.push_back(32'h1234_5678);
        n_exp_inc++;
        start_fetch(32'h0000_0700);
        repeat (16) step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        chk("wd_late_ack_no_err", {63'd0, fetch_err}, 64'd0);
        chk("wd_late_ack_valid", {63'd0, ir_valid}, 64'd1);
        release_ir();
        step();

        chk("pc_inc_total", pc_inc_seen, n_exp_inc);
        chk("req_queue_drained", exp_req.size(), 64'd0);
        chk("ir_queue_drained", exp_ir.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
